// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter generator:
// run/halt state encodings, the default reset vector and the PC step sizes.
package pc_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_BOOT = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_HALT = 2'd2;

  localparam logic [63:0] RESET_VEC_DEFAULT = 64'h0000_0000_8000_0000;

  localparam logic [2:0] STEP_C = 3'd2;
  localparam logic [2:0] STEP_W = 3'd4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. When full, a push overwrites the oldest entry.
// A simultaneous pop and push replaces the top entry in place.
module pc_ras #(
  parameter int RAS_DEPTH = 4,
  parameter int XLEN      = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_addr,
  output logic [XLEN-1:0] top_addr,
  output logic            empty
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] entries_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d, top_idx, wr_idx;
  logic [CW-1:0]   count_q, count_d;
  logic            wr_en, do_pop;

  // ptr_q is the next free slot, so the top entry sits one below it
  assign top_idx  = ptr_q - PW'(1);
  assign top_addr = entries_q[top_idx];
  assign empty    = (count_q == '0);

  // NOTE: every signal assigned here gets a default first; otherwise a path
  // that skips an assignment would infer a latch.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    do_pop  = pop && !empty;
    if (clear) begin
      ptr_d   = '0;
      count_d = '0;
    end else if (do_pop && push) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (do_pop) begin
      ptr_d   = top_idx;
      count_d = count_q - CW'(1);
    end else if (push) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + PW'(1);
      if (count_q != CW'(RAS_DEPTH)) count_d = count_q + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count_q alone decides
  // which entries are meaningful, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (wr_en) entries_q[wr_idx] <= push_addr;
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: BOOT/RUN/HALT control, prioritised redirects,
// compressed-aware sequential stepping and return-address prediction.
module pc_gen
  import pc_pkg::*;
#(
  parameter int          XLEN      = 64,
  parameter logic [63:0] RESET_VEC = RESET_VEC_DEFAULT,
  parameter int          RAS_DEPTH = 4,
  parameter bit          SUPPORT_C = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_ref_pc,
  input  logic [XLEN-1:0] br_imm,
  input  logic            jmp_taken,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            trap_taken,
  input  logic [XLEN-1:0] trap_target,
  input  logic            halt_req,
  input  logic            call_hint,
  input  logic            ret_hint,
  input  logic            inst_c,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  output logic            flush,
  output logic            misaligned
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, seq_pc, ras_top;
  logic            flush_q, flush_d;
  logic            accept, ras_push, ras_pop, ras_clear, ras_empty;
  logic [2:0]      step;

  assign fetch_valid = (state_q == ST_RUN);
  assign fetch_pc    = pc_q;
  assign flush       = flush_q;
  assign misaligned  = pc_q[0] | (!SUPPORT_C & pc_q[1]);
  assign accept      = fetch_valid & fetch_ready & !stall;
  assign step        = (SUPPORT_C && inst_c) ? STEP_C : STEP_W;
  assign seq_pc      = pc_q + XLEN'(step);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    flush_d   = 1'b0;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_clear = 1'b0;
    if (state_q == ST_BOOT) begin
      state_d = ST_RUN;
    end else if (trap_taken) begin
      // trap also serves as the only way out of HALT
      pc_d      = trap_target;
      flush_d   = 1'b1;
      ras_clear = 1'b1;
      state_d   = ST_RUN;
    end else if (state_q == ST_RUN) begin
      if (br_taken) begin
        pc_d    = br_ref_pc + br_imm;
        flush_d = 1'b1;
      end else if (jmp_taken) begin
        pc_d    = {jmp_target[XLEN-1:1], 1'b0};
        flush_d = 1'b1;
      end else if (ret_hint && accept && !ras_empty) begin
        pc_d     = ras_top;
        flush_d  = 1'b1;
        ras_pop  = 1'b1;
        ras_push = call_hint;
      end else if (halt_req) begin
        state_d = ST_HALT;
      end else if (accept) begin
        pc_d     = seq_pc;
        ras_push = call_hint;
      end
    end else if (state_q != ST_HALT) begin
      state_d = ST_BOOT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VEC[XLEN-1:0];
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
    end
  end

  pc_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .XLEN      (XLEN)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .clear     (ras_clear),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_addr (seq_pc),
    .top_addr  (ras_top),
    .empty     (ras_empty)
  );

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: expected PC/valid/flush triples are queued as
// stimulus is applied and compared after the following clock edge.
module tb_pc_gen;
  import pc_pkg::*;

  typedef struct {
    logic [63:0] pc;
    logic        valid;
    logic        flush;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken, jmp_taken, trap_taken, halt_req;
  logic        call_hint, ret_hint, inst_c, fetch_ready;
  logic [63:0] br_ref_pc, br_imm, jmp_target, trap_target;
  logic        fetch_valid, flush, misaligned;
  logic [63:0] fetch_pc;
  logic        nc_valid, nc_flush, nc_misaligned;
  logic [63:0] nc_pc;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  pc_gen #(.XLEN(64), .RESET_VEC(64'h8000_0000), .RAS_DEPTH(4), .SUPPORT_C(1'b1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_ref_pc(br_ref_pc),
    .br_imm(br_imm), .jmp_taken(jmp_taken), .jmp_target(jmp_target),
    .trap_taken(trap_taken), .trap_target(trap_target), .halt_req(halt_req),
    .call_hint(call_hint), .ret_hint(ret_hint), .inst_c(inst_c),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .flush(flush), .misaligned(misaligned)
  );

  pc_gen #(.XLEN(64), .RESET_VEC(64'h8000_0000), .RAS_DEPTH(4), .SUPPORT_C(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_ref_pc(br_ref_pc),
    .br_imm(br_imm), .jmp_taken(jmp_taken), .jmp_target(jmp_target),
    .trap_taken(trap_taken), .trap_target(trap_target), .halt_req(halt_req),
    .call_hint(call_hint), .ret_hint(ret_hint), .inst_c(inst_c),
    .fetch_valid(nc_valid), .fetch_ready(fetch_ready), .fetch_pc(nc_pc),
    .flush(nc_flush), .misaligned(nc_misaligned)
  );

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queue the expectation, advance one clock, then pop and compare.
  task automatic cyc(input logic [63:0] pc, input logic v, input logic f, input string tag);
    exp_t e;
    sb_q.push_back('{pc, v, f, tag});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk(fetch_pc, e.pc, {e.tag, ".pc"});
    chk({63'd0, fetch_valid}, {63'd0, e.valid}, {e.tag, ".valid"});
    chk({63'd0, flush}, {63'd0, e.flush}, {e.tag, ".flush"});
  endtask

  task automatic idle();
    stall = 0; br_taken = 0; jmp_taken = 0; trap_taken = 0; halt_req = 0;
    call_hint = 0; ret_hint = 0; inst_c = 0; fetch_ready = 1;
  endtask

  initial begin
    idle();
    br_ref_pc = '0; br_imm = '0; jmp_target = '0; trap_target = '0;
    rst = 1;
    #1;

    // reset and boot
    cyc(64'h8000_0000, 0, 0, "reset");
    rst = 0;
    cyc(64'h8000_0000, 1, 0, "boot");
    cyc(64'h8000_0004, 1, 0, "seq1");
    cyc(64'h8000_0008, 1, 0, "seq2");

    // compressed step; the SUPPORT_C=0 copy always steps by 4
    inst_c = 1;
    cyc(64'h8000_000a, 1, 0, "comp");
    chk(nc_pc, 64'h8000_000c, "comp_nc.pc");
    chk({63'd0, misaligned}, 64'd0, "comp.misaligned");
    inst_c = 0;

    // trap beats branch and jump; flush lasts one cycle
    trap_taken = 1; trap_target = 64'h100;
    br_taken = 1; br_ref_pc = 64'h8000_0010; br_imm = -64'sd16;
    jmp_taken = 1; jmp_target = 64'h2003;
    cyc(64'h100, 1, 1, "prio");
    idle();
    cyc(64'h104, 1, 0, "prio_after");

    jmp_taken = 1; jmp_target = 64'h2003;
    cyc(64'h2002, 1, 1, "jmp_clr0");
    chk({63'd0, nc_misaligned}, 64'd1, "jmp_nc.misaligned");
    chk({63'd0, misaligned}, 64'd0, "jmp.misaligned");
    idle();
    br_taken = 1; br_ref_pc = 64'h8000_0010; br_imm = -64'sd16;
    cyc(64'h8000_0000, 1, 1, "br_neg");
    idle();
    cyc(64'h8000_0004, 1, 0, "br_after");

    // stall and not-ready both hold; branch still redirects under stall
    stall = 1;
    for (int i = 0; i < 3; i++) cyc(64'h8000_0004, 1, 0, "stall_hold");
    br_taken = 1; br_ref_pc = 64'h1000; br_imm = 64'h1;
    cyc(64'h1001, 1, 1, "br_in_stall");
    chk({63'd0, misaligned}, 64'd1, "br_odd.misaligned");
    idle();
    fetch_ready = 0;
    for (int i = 0; i < 3; i++) cyc(64'h1001, 1, 0, "notready_hold");
    idle();

    // single call / return
    jmp_taken = 1; jmp_target = 64'h1000;
    cyc(64'h1000, 1, 1, "to_call");
    idle(); call_hint = 1;
    cyc(64'h1004, 1, 0, "call");
    idle(); jmp_taken = 1; jmp_target = 64'h3000;
    cyc(64'h3000, 1, 1, "to_3000");
    idle(); ret_hint = 1;
    cyc(64'h1004, 1, 1, "ret_pred");
    cyc(64'h1008, 1, 0, "ret_empty");
    idle();

    // five calls into a four-deep stack, then five returns
    call_hint = 1;
    cyc(64'h100c, 1, 0, "call1");
    cyc(64'h1010, 1, 0, "call2");
    cyc(64'h1014, 1, 0, "call3");
    cyc(64'h1018, 1, 0, "call4");
    cyc(64'h101c, 1, 0, "call5");
    idle(); jmp_taken = 1; jmp_target = 64'h4000;
    cyc(64'h4000, 1, 1, "to_4000");
    idle(); ret_hint = 1;
    cyc(64'h101c, 1, 1, "ret1");
    cyc(64'h1018, 1, 1, "ret2");
    cyc(64'h1014, 1, 1, "ret3");
    cyc(64'h1010, 1, 1, "ret4");
    cyc(64'h1014, 1, 0, "ret5_seq");
    idle();

    // call+ret together replaces the top entry
    call_hint = 1;
    cyc(64'h1018, 1, 0, "swap_call");
    idle(); jmp_taken = 1; jmp_target = 64'h5000;
    cyc(64'h5000, 1, 1, "to_5000");
    idle(); call_hint = 1; ret_hint = 1;
    cyc(64'h1018, 1, 1, "swap");
    idle(); ret_hint = 1;
    cyc(64'h5004, 1, 1, "swap_ret");
    idle();

    // trap empties the stack
    call_hint = 1;
    cyc(64'h5008, 1, 0, "pre_trap_call");
    idle(); trap_taken = 1; trap_target = 64'h100;
    cyc(64'h100, 1, 1, "trap_clr");
    idle(); ret_hint = 1;
    cyc(64'h104, 1, 0, "ret_after_trap");
    idle();

    // redirect beats halt
    halt_req = 1; jmp_taken = 1; jmp_target = 64'h300;
    cyc(64'h300, 1, 1, "halt_vs_jmp");
    idle();
    cyc(64'h304, 1, 0, "still_run");

    // halt, hold, trap out, halt again, reset out
    halt_req = 1;
    cyc(64'h304, 0, 0, "halt_enter");
    idle();
    for (int i = 0; i < 10; i++) cyc(64'h304, 0, 0, "halt_hold");
    trap_taken = 1; trap_target = 64'h200;
    cyc(64'h200, 1, 1, "halt_trap");
    idle();
    cyc(64'h204, 1, 0, "halt_resume");
    halt_req = 1;
    cyc(64'h204, 0, 0, "halt2");
    idle(); rst = 1;
    cyc(64'h8000_0000, 0, 0, "rst_in_halt");
    rst = 0;
    cyc(64'h8000_0000, 1, 0, "reboot");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
